// File: rtl/key_debounce4_pkg.sv
// Shared constants for the key conditioner and the encoder-side benches.
// Holds the default debounce length and the counter-width helper.
`timescale 10ps/1ps

package key_debounce4_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int unsigned NUM_KEYS                = 4;

    // Counter must reach DEBOUNCE_CYCLES-1; keep at least one bit for N=1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce4_debounce_cell.sv
// One key line: 2-flop synchroniser, hold counter, accepted level and
// a one-cycle pulse on each accepted rising edge.
`timescale 10ps/1ps

module debounce_cell
    import key_debounce4_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press
);

    localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= key;
            s2      <= s1;
            press_q <= 1'b0;
            if (s2 == level_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // s2 differs from level here, so s2=1 means a 0->1 acceptance.
                level_q <= s2;
                press_q <= s2;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/key_debounce4.sv
// Four independent debounced key lines feeding the 4-to-2 encoder inputs
// A0..A3, plus per-line rising-edge pulses. Wiring only.
`timescale 10ps/1ps

module key_debounce4
    import key_debounce4_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic KEY0,
    input  logic KEY1,
    input  logic KEY2,
    input  logic KEY3,
    output logic A0,
    output logic A1,
    output logic A2,
    output logic A3,
    output logic PRESS0,
    output logic PRESS1,
    output logic PRESS2,
    output logic PRESS3
);

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_line0 (
        .clk   (clk),
        .rst   (rst),
        .key   (KEY0),
        .level (A0),
        .press (PRESS0)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_line1 (
        .clk   (clk),
        .rst   (rst),
        .key   (KEY1),
        .level (A1),
        .press (PRESS1)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_line2 (
        .clk   (clk),
        .rst   (rst),
        .key   (KEY2),
        .level (A2),
        .press (PRESS2)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_line3 (
        .clk   (clk),
        .rst   (rst),
        .key   (KEY3),
        .level (A3),
        .press (PRESS3)
    );

endmodule

// File: tb/tb_key_debounce4.sv
// Bench for key_debounce4 at the default length and at length 1, checked
// against a window-rule model built from the recorded key/reset history.
`timescale 10ps/1ps

module tb_key_debounce4;

    localparam int MAXE = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key = '0;

    logic [3:0] a4, p4, a1, p1;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    key_debounce4 #(.DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .KEY0(key[0]), .KEY1(key[1]), .KEY2(key[2]), .KEY3(key[3]),
        .A0(a4[0]), .A1(a4[1]), .A2(a4[2]), .A3(a4[3]),
        .PRESS0(p4[0]), .PRESS1(p4[1]), .PRESS2(p4[2]), .PRESS3(p4[3])
    );

    key_debounce4 #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .KEY0(key[0]), .KEY1(key[1]), .KEY2(key[2]), .KEY3(key[3]),
        .A0(a1[0]), .A1(a1[1]), .A2(a1[2]), .A3(a1[3]),
        .PRESS0(p1[0]), .PRESS1(p1[1]), .PRESS2(p1[2]), .PRESS3(p1[3])
    );

    // History of what each posedge saw on the inputs.
    logic [3:0] keyh [0:MAXE-1];
    logic       rsth [0:MAXE-1];
    int         e        = -1;
    int         last_rst = -1;

    logic [3:0] m4a = '0, m4p = '0, m1a = '0, m1p = '0;

    // Synchronised value acted on at edge k: the key seen two edges earlier,
    // or 0 if either of the intervening edges was a reset.
    function automatic logic s2_at(input int k, input int i);
        if (k < 2) return 1'b0;
        if (rsth[k-1] || rsth[k-2]) return 1'b0;
        return keyh[k-2][i];
    endfunction

    // A new level is accepted at edge e if the synchronised value differed
    // from the held level on each of the last n edges, none of them a reset.
    function automatic logic accept(input int n, input int i, input logic lvl);
        if (e - n + 1 <= last_rst) return 1'b0;
        for (int j = 0; j < n; j++)
            if (s2_at(e - j, i) == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] k);
        logic acc;
        rst = r;
        key = k;
        @(posedge clk);
        e++;
        if (e >= MAXE) begin
            $display("FAIL history: edge budget %0d exceeded", MAXE);
            $fatal(1, "history overflow");
        end
        keyh[e] = k;
        rsth[e] = r;
        if (r) begin
            last_rst = e;
            m4a = '0; m4p = '0; m1a = '0; m1p = '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                acc    = accept(4, i, m4a[i]);
                m4p[i] = acc & ~m4a[i];
                if (acc) m4a[i] = ~m4a[i];
                acc    = accept(1, i, m1a[i]);
                m1p[i] = acc & ~m1a[i];
                if (acc) m1a[i] = ~m1a[i];
            end
        end
        #1;
        check("A_n4", a4, m4a);
        check("PRESS_n4", p4, m4p);
        check("A_n1", a1, m1a);
        check("PRESS_n1", p1, m1p);
    endtask

    initial begin : stim
        logic [3:0] kv;
        int         flip_div;

        // Reset with all keys held high, then release and re-debounce.
        step(1'b1, 4'b1111);
        check("rst_A", a4, 4'b0000);
        check("rst_PRESS", p4, 4'b0000);
        step(1'b1, 4'b1111);
        check("rst_A2", a4, 4'b0000);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 4'b1111);
            check("rel_A", a4, (i >= 6) ? 4'b1111 : 4'b0000);
            check("rel_PRESS", p4, (i == 6) ? 4'b1111 : 4'b0000);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0000);

        // Clean press on KEY2 only.
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 4'b0100);
            check("press2_A", a4, (i >= 6) ? 4'b0100 : 4'b0000);
            check("press2_P", p4, (i == 6) ? 4'b0100 : 4'b0000);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0000);

        // Bounce on KEY1: 3 high, 1 low, 2 high, then low.
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);
        for (int i = 0; i < 2; i++) step(1'b0, 4'b0010);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0000);
            check("bounce_A1", a4, 4'b0000);
            check("bounce_P1", p4, 4'b0000);
        end

        // Release on KEY0 after it has been accepted high.
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0001);
        check("pre_rel_A0", a4, 4'b0001);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 4'b0000);
            check("rel0_A", a4, (i >= 6) ? 4'b0000 : 4'b0001);
            check("rel0_P", p4, 4'b0000);
        end

        // Reset mid-count with KEY3 held high.
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1000);
        step(1'b1, 4'b1000);
        check("midrst_A", a4, 4'b0000);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 4'b1000);
            check("midrst_A3", a4, (i >= 6) ? 4'b1000 : 4'b0000);
            check("midrst_P3", p4, (i == 6) ? 4'b1000 : 4'b0000);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0000);

        // Simultaneous rise on KEY0 and KEY3.
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 4'b1001);
            check("sim_A", a4, (i >= 6) ? 4'b1001 : 4'b0000);
            check("sim_P", p4, (i == 6) ? 4'b1001 : 4'b0000);
        end

        // Randomised bouncing on all lines with occasional resets.
        kv = 4'b1001;
        for (int blk = 0; blk < 40; blk++) begin
            flip_div = int'($urandom_range(2, 14));
            for (int c = 0; c < 50; c++) begin
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, flip_div - 1) == 0) kv[i] = ~kv[i];
                step(($urandom_range(0, 149) == 0), kv);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/key_debounce4.md
# key_debounce4

Four-line input conditioner sitting directly upstream of the 4-to-2 encoder. It synchronises four raw, asynchronous, bouncing key lines into the clock domain and debounces each one independently. It drives clean level outputs A0..A3 that wire straight onto the encoder inputs of the same names. It also emits a one-cycle rising-edge pulse per line for downstream event logic.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive post-sync cycles a new level must hold before it is accepted; legal range 1..65535
- clk  input  1  single system clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high; sampled on posedge clk
- KEY0..KEY3  input  1 each  raw asynchronous key lines, active-high, may bounce
- A0..A3  output  1 each  debounced level of KEY0..KEY3; registered
- PRESS0..PRESS3  output  1 each  one-cycle pulse when the matching An rises; registered

## Operation
- Each line has its own:
  - 2-flop synchroniser, s1 then s2
  - stable level register, driving An
  - counter cnt, width max(1, clog2(DEBOUNCE_CYCLES))
  - pulse register, driving PRESSn
- On every posedge with rst=0, per line:
  - s1 <= KEYn; s2 <= s1
  - if s2 == level: cnt <= 0
  - else if cnt == DEBOUNCE_CYCLES-1: level <= s2, cnt <= 0
  - else: cnt <= cnt+1
  - PRESSn <= 1 only on the edge where level goes 0->1; else 0
- Glitch rejection: if s2 returns to the current level before the count completes, cnt clears and level is unchanged.
- Release (1->0) is debounced identically. It produces no pulse.
- Lines are fully independent. Simultaneous changes on several lines each complete on their own schedule, and several An may be high at once. One-hot enforcement is not this block's job.
- rst=1 on a posedge clears s1, s2, level, cnt and PRESS on all lines, regardless of count progress. A key held high through reset is re-debounced from scratch after release.
- DEBOUNCE_CYCLES=1: a new level is accepted on the first edge at which s2 differs.

## Timing
- Reset values: A0..A3=0, PRESS0..PRESS3=0; internal s1, s2 and cnt are also 0.
- Latency: raw change settles before edge 0; s1 updates at edge 1, s2 at edge 2, An changes at edge 2+DEBOUNCE_CYCLES.
  - Default N=4: An changes at edge 6.
- PRESSn is high for exactly the one cycle following the edge at which An rises, coincident with An's first high cycle.
- After rst deasserts, the first non-reset posedge counts as edge 1 for a key already held high.
- A bounce on s2 lasting fewer than DEBOUNCE_CYCLES cycles never reaches An.
- No combinational path from KEYn to any output.

## Structure
- Shared header holds the default DEBOUNCE_CYCLES constant and the timescale (10ps/1ps), so the encoder and debouncer benches agree.
- Natural sub-module: debounce_cell, one line covering sync, counter, level and pulse, parameterised by DEBOUNCE_CYCLES. key_debounce4 instantiates it four times; top level is wiring only.
- Top-level output names A0..A3 match the encoder inputs, for direct port-by-name hookup.

## Test plan
- Reset: rst=1 for 2 cycles with KEY=4'b1111 -> A0..A3=0 and PRESS=0 throughout reset. After release, all An rise at edge 6 and each PRESSn pulses for 1 cycle.
- Clean press, N=4: KEY2 0->1 held -> A2 rises at edge 6, PRESS2=1 for exactly one cycle. Other lines stay 0.
- Bounce rejection: KEY1 high 3 cycles, low 1, high 2, low -> A1 stays 0 and PRESS1 never fires.
- Release: A0=1, then KEY0 1->0 held -> A0 falls at edge 6 and PRESS0 stays 0.
- Reset mid-count: KEY3 rises, rst=1 asserted at edge 4 while KEY3 stays high -> A3=0 and cnt=0. After release, A3 rises 6 edges later with one PRESS3 pulse.
- Simultaneous: KEY0 and KEY3 rise on the same cycle -> A0 and A3 rise together at edge 6, both PRESS pulses fire together. Check the encoder output against both lines high.
